// File: rtl/systolic_a_feeder.sv
// ---------------------------------------------------------------------------
// systolic_a_feeder
//
// Reads one NxN operand matrix from DATAMEM into a local buffer, then streams
// it into the west edge of an NxN systolic array in skewed order: lane r lags
// lane 0 by r cycles.
//
// The matrix is stored row-major as N*N consecutive words starting at
// base_addr. Word k lands in buffer row k/N, column k%N. During streaming,
// lane r carries row r, and column c of that row appears on stream step r+c.
//
// Ports
//   clk          rising-edge clock, shared with DATAMEM
//   rst_n        asynchronous active-low reset
//   start        run request, sampled only while idle
//   base_addr    matrix base address, latched when start is accepted
//   mem_addr     DATAMEM read address (base_reg + idx while loading)
//   mem_rd_en    high while loading
//   mem_data_in  DATAMEM read data, combinational in the same cycle
//   a_data       registered lane data, lane r at [r*DATA_W +: DATA_W]
//   a_valid      registered per-lane valid
//   busy         high whenever the block is not idle
//   done         registered one-cycle completion pulse
// ---------------------------------------------------------------------------
module systolic_a_feeder #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16,
    parameter int N      = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [ADDR_W-1:0]   base_addr,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic                mem_rd_en,
    input  logic [DATA_W-1:0]   mem_data_in,
    output logic [N*DATA_W-1:0] a_data,
    output logic [N-1:0]        a_valid,
    output logic                busy,
    output logic                done
);

    localparam int NN    = N * N;
    localparam int IDX_W = (NN > 1) ? $clog2(NN) : 1;
    // The step counter only needs to reach 2N-2.
    localparam int T_W   = $clog2(2 * N);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NN - 1);
    localparam logic [T_W-1:0]   LAST_T   = T_W'(2 * N - 2);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        STREAM = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t              state;
    state_t              state_nxt;

    logic [ADDR_W-1:0]   base_reg;
    logic [IDX_W-1:0]    idx;
    logic [T_W-1:0]      t;
    logic [DATA_W-1:0]   mat_buf [N][N];

    logic [N*DATA_W-1:0] stream_data;
    logic [N-1:0]        stream_valid;

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                if (idx == LAST_IDX) begin
                    state_nxt = STREAM;
                end
            end
            STREAM: begin
                if (t == LAST_T) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Combinational outputs. The address adder wraps modulo 2^ADDR_W, so a
    // matrix may straddle the top of the address space.
    // -----------------------------------------------------------------------
    always_comb begin
        mem_addr  = base_reg;
        mem_rd_en = 1'b0;
        if (state == LOAD) begin
            mem_addr  = base_reg + ADDR_W'(idx);
            mem_rd_en = 1'b1;
        end
    end

    assign busy = (state != IDLE);

    // -----------------------------------------------------------------------
    // Skew selection for the current stream step t. Lane r presents column
    // c = t - r when that column exists. Otherwise the lane is in its lead-in
    // or drain bubble, and it outputs zero with valid low.
    // -----------------------------------------------------------------------
    always_comb begin
        stream_data  = '0;
        stream_valid = '0;
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                if (t == T_W'(r + c)) begin
                    stream_data[r*DATA_W +: DATA_W] = mat_buf[r][c];
                    stream_valid[r]                 = 1'b1;
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Counters and base latch
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_reg <= '0;
            idx      <= '0;
            t        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        base_reg <= base_addr;
                        idx      <= '0;
                    end
                end
                LOAD: begin
                    if (idx == LAST_IDX) begin
                        idx <= '0;
                        t   <= '0;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                STREAM: begin
                    t <= t + 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Operand buffer capture, one word per load cycle
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < N; r++) begin
                for (int c = 0; c < N; c++) begin
                    mat_buf[r][c] <= '0;
                end
            end
        end else if (state == LOAD) begin
            for (int r = 0; r < N; r++) begin
                for (int c = 0; c < N; c++) begin
                    if (idx == IDX_W'(r * N + c)) begin
                        mat_buf[r][c] <= mem_data_in;
                    end
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Registered array-edge outputs and completion pulse
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_data  <= '0;
            a_valid <= '0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                STREAM: begin
                    a_data  <= stream_data;
                    a_valid <= stream_valid;
                end
                DONE: begin
                    a_data  <= '0;
                    a_valid <= '0;
                    done    <= 1'b1;
                end
                default: begin
                    a_data  <= '0;
                    a_valid <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_systolic_a_feeder.sv
module tb_systolic_a_feeder;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 16;
    localparam int N      = 4;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                start = 1'b0;
    logic [ADDR_W-1:0]   base_addr = '0;
    logic [ADDR_W-1:0]   mem_addr;
    logic                mem_rd_en;
    logic [DATA_W-1:0]   mem_data_in;
    logic [N*DATA_W-1:0] a_data;
    logic [N-1:0]        a_valid;
    logic                busy;
    logic                done;

    logic [15:0] mem [0:65535];
    assign mem_data_in = mem[mem_addr];

    int n_cmp = 0;
    int n_bad = 0;

    logic [63:0] snap_data  [7];
    logic [3:0]  snap_valid [7];

    always #5 clk = ~clk;

    systolic_a_feeder #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .N(N)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .base_addr   (base_addr),
        .mem_addr    (mem_addr),
        .mem_rd_en   (mem_rd_en),
        .mem_data_in (mem_data_in),
        .a_data      (a_data),
        .a_valid     (a_valid),
        .busy        (busy),
        .done        (done)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Expected word on lane r at stream step s for a matrix based at base.
    function automatic logic [15:0] exp_lane(input logic [15:0] base, input int r, input int s);
        int c;
        logic [15:0] a;
        c = s - r;
        if (c < 0 || c >= N) return 16'h0000;
        a = base + 16'(r * N + c);
        return mem[a];
    endfunction

    // Called at P0+1 (start just accepted); returns at P25+1.
    task automatic run_body(input logic [15:0] base, input bit keep_start, input int inject_k);
        logic [63:0] ed;
        logic [3:0]  ev;
        logic [15:0] ea;
        if (!keep_start) start = 1'b0;
        chk("busy_after_accept", 64'(busy), 64'd1);
        for (int k = 0; k < 16; k++) begin
            ea = base + 16'(k);
            chk($sformatf("load_addr%0d", k), 64'(mem_addr), 64'(ea));
            chk($sformatf("load_rd_en%0d", k), 64'(mem_rd_en), 64'd1);
            if (inject_k >= 0 && k == inject_k) begin
                start     = 1'b1;
                base_addr = 16'h0040;
            end else if (inject_k >= 0 && k == inject_k + 1) begin
                start = 1'b0;
            end
            tick();
        end
        chk("pre_stream_valid", 64'(a_valid), 64'd0);
        chk("pre_stream_rd_en", 64'(mem_rd_en), 64'd0);
        chk("pre_stream_addr", 64'(mem_addr), 64'(base));
        tick();
        for (int s = 0; s < 7; s++) begin
            ed = '0;
            ev = '0;
            for (int r = 0; r < N; r++) begin
                ed[r*16 +: 16] = exp_lane(base, r, s);
                ev[r]          = (s - r >= 0) && (s - r < N);
            end
            chk($sformatf("step%0d_data", s), a_data, ed);
            chk($sformatf("step%0d_valid", s), 64'(a_valid), 64'(ev));
            chk($sformatf("step%0d_done", s), 64'(done), 64'd0);
            chk($sformatf("step%0d_busy", s), 64'(busy), 64'd1);
            snap_data[s]  = a_data;
            snap_valid[s] = a_valid;
            tick();
        end
        chk("done_pulse", 64'(done), 64'd1);
        chk("done_busy", 64'(busy), 64'd0);
        chk("done_valid", 64'(a_valid), 64'd0);
        chk("done_data", a_data, 64'd0);
        tick();
        chk("done_cleared", 64'(done), 64'd0);
        if (keep_start) begin
            chk("reaccept_busy", 64'(busy), 64'd1);
            chk("reaccept_addr", 64'(mem_addr), 64'(base_addr));
        end else begin
            chk("post_idle_busy", 64'(busy), 64'd0);
        end
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
        for (int k = 0; k < 16; k++) mem[16 + k] = 16'(k + 1);
        for (int k = 0; k < 16; k++) mem[k] = 16'hB000 + 16'(k);
        mem[16'hFFFE] = 16'hA000;
        mem[16'hFFFF] = 16'hA001;

        // Reset state
        #2;
        chk("rst_valid", 64'(a_valid), 64'd0);
        chk("rst_data", a_data, 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_rd_en", 64'(mem_rd_en), 64'd0);
        chk("rst_addr", 64'(mem_addr), 64'd0);
        #10 rst_n = 1'b1;

        // Idle quiescence
        for (int i = 0; i < 50; i++) begin
            tick();
            chk("idle_valid", 64'(a_valid), 64'd0);
            chk("idle_done", 64'(done), 64'd0);
            chk("idle_rd_en", 64'(mem_rd_en), 64'd0);
        end

        // Basic load/stream at base 16
        base_addr = 16'd16;
        start     = 1'b1;
        tick();
        run_body(16'd16, 1'b0, -1);
        chk("basic_s0_lane0", 64'(snap_data[0][15:0]), 64'd1);
        chk("basic_s0_valid", 64'(snap_valid[0]), 64'b0001);
        chk("basic_s1_lanes", 64'(snap_data[1][31:0]), {32'd0, 16'd5, 16'd2});
        chk("basic_s1_valid", 64'(snap_valid[1]), 64'b0011);
        chk("basic_s3_lanes", snap_data[3], {16'd13, 16'd10, 16'd7, 16'd4});
        chk("basic_s3_valid", 64'(snap_valid[3]), 64'b1111);
        chk("basic_s6_lanes", snap_data[6], {16'd16, 48'd0});
        chk("basic_s6_valid", 64'(snap_valid[6]), 64'b1000);

        // Address wrap
        tick();
        base_addr = 16'hFFFE;
        start     = 1'b1;
        tick();
        run_body(16'hFFFE, 1'b0, -1);
        chk("wrap_word0", 64'(snap_data[0][15:0]), 64'h0000_0000_0000_A000);
        chk("wrap_word2", 64'(snap_data[2][15:0]), 64'h0000_0000_0000_B000);

        // Start while busy
        tick();
        base_addr = 16'd16;
        start     = 1'b1;
        tick();
        run_body(16'd16, 1'b0, 4);
        for (int i = 0; i < 30; i++) begin
            tick();
            chk("ignored_start_done", 64'(done), 64'd0);
            chk("ignored_start_busy", 64'(busy), 64'd0);
        end

        // Reset mid-STREAM at step 3
        base_addr = 16'd16;
        start     = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 16; k++) tick();
        for (int s = 0; s < 4; s++) tick();
        chk("pre_abort_valid", 64'(a_valid), 64'b1111);
        #1 rst_n = 1'b0;
        #1;
        chk("abort_valid", 64'(a_valid), 64'd0);
        chk("abort_data", a_data, 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_rd_en", 64'(mem_rd_en), 64'd0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 30; i++) begin
            tick();
            chk("post_abort_done", 64'(done), 64'd0);
            chk("post_abort_busy", 64'(busy), 64'd0);
        end
        base_addr = 16'd16;
        start     = 1'b1;
        tick();
        run_body(16'd16, 1'b0, -1);
        chk("post_abort_s3", snap_data[3], {16'd13, 16'd10, 16'd7, 16'd4});

        // Back-to-back with start held high
        tick();
        base_addr = 16'd0;
        start     = 1'b1;
        tick();
        base_addr = 16'd16;
        run_body(16'd0, 1'b1, -1);
        chk("b2b_first_s3", snap_data[3], {16'hB00C, 16'hB009, 16'hB006, 16'hB003});
        run_body(16'd16, 1'b0, -1);
        chk("b2b_second_s3", snap_data[3], {16'd13, 16'd10, 16'd7, 16'd4});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
